// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - ALU op codes and FSM states shared by the multiply/divide unit
package mul_div_unit_pkg;

  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Ops that occupy the unit for more than the issue cycle and must stall the pipe.
  function automatic logic is_mdu_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// rtl/mul_div_unit_div_iter.sv - restoring radix-2 divider datapath, one quotient bit per step
module mul_div_unit_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_next_o,
  output logic [WIDTH-1:0] rem_next_o
);

  logic [WIDTH-1:0] quot_q, rem_q, dvsr_q;
  logic [WIDTH:0]   shifted, trial;
  logic             ge;

  // The dividend shifts out of quot_q from the top while quotient bits shift in below.
  always_comb begin
    shifted     = {rem_q, quot_q[WIDTH-1]};
    trial       = shifted - {1'b0, dvsr_q};
    ge          = ~trial[WIDTH];
    rem_next_o  = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_next_o = {quot_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      quot_q <= dividend_i;
      rem_q  <= '0;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      quot_q <= quot_next_o;
      rem_q  <= rem_next_o;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MULT/DIV unit owning HI/LO; MDU_FAST_MUL_EN selects a single-cycle multiply
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [7:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               mneg_q, mneg_d, qneg_q, qneg_d, rneg_q, rneg_d;

  logic               signed_op, a_neg, b_neg, last_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_next;
  logic               div_load, div_step;
  logic [WIDTH-1:0]   div_quot, div_rem;

  mul_div_unit_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quot_next_o (div_quot),
    .rem_next_o  (div_rem)
  );

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{a_neg}}, a_i} * {{WIDTH{b_neg}}, b_i};
`endif

  assign signed_op = (op_i == EXE_MULT_OP) || (op_i == EXE_DIV_OP);
  assign a_neg     = signed_op & a_i[WIDTH-1];
  assign b_neg     = signed_op & b_i[WIDTH-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Shift-add with the multiplier in the low half of the accumulator, consumed LSB first.
  assign mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_acc_next = {mul_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mneg_d   = mneg_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div_load = 1'b0;
    div_step = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          case (op_i)
            EXE_MULT_OP, EXE_MULTU_OP: begin
`ifdef MDU_FAST_MUL_EN
              {hi_d, lo_d} = fast_prod;
              state_d      = ST_DONE;
`else
              acc_d   = {{WIDTH{1'b0}}, b_mag};
              mcand_d = a_mag;
              mneg_d  = a_neg ^ b_neg;
              cnt_d   = '0;
              state_d = ST_MUL;
`endif
            end
            EXE_DIV_OP, EXE_DIVU_OP: begin
              if (b_i == '0) begin
                lo_d    = '1;
                hi_d    = a_i;
                state_d = ST_DONE;
              end else begin
                div_load = 1'b1;
                qneg_d   = a_neg ^ b_neg;
                rneg_d   = a_neg;
                cnt_d    = '0;
                state_d  = ST_DIV;
              end
            end
            EXE_MTHI_OP: hi_d = a_i;
            EXE_MTLO_OP: lo_d = a_i;
            default: ;
          endcase
        end
        ST_MUL: begin
          acc_d = mul_acc_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            {hi_d, lo_d} = mneg_q ? -mul_acc_next : mul_acc_next;
            state_d      = ST_DONE;
          end
        end
        ST_DIV: begin
          div_step = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (last_step) begin
            lo_d    = qneg_q ? -div_quot : div_quot;
            hi_d    = rneg_q ? -div_rem : div_rem;
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mneg_q  <= mneg_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign stall_o = ~flush_i & (((state_q == ST_IDLE) & start_i & is_mdu_op(op_i)) |
                               (state_q == ST_MUL) | (state_q == ST_DIV));
  assign done_o  = (state_q == ST_DONE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit (honours MDU_FAST_MUL_EN)
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic [7:0] RST_OP = EXE_DIVU_OP;
`else
  localparam int MUL_LAT = 33;
  localparam logic [7:0] RST_OP = EXE_MULTU_OP;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        resetn, start_i, flush_i;
  logic [7:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && done_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 64'(done_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_hi"}, 64'(hi_o), 64'(e.hi));
          check({e.name, "_lo"}, 64'(lo_o), 64'(e.lo));
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat);
    int edges;
    int bad_stall;
    sb_q.push_back('{name, ehi, elo});
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1;
    check({name, "_stall_c0"}, 64'(stall_o), 64'd1);
    edges = 0;
    bad_stall = 0;
    while (edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (done_o) break;
      if (!stall_o) bad_stall++;
    end
    check({name, "_latency"}, 64'(edges), 64'(elat));
    check({name, "_stall_busy"}, 64'(bad_stall), 64'd0);
    check({name, "_stall_done"}, 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 8'h00;
  endtask

  initial begin : stim
    resetn = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 8'h00; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max2", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mult_neg3x7", EXE_MULT_OP, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mult_minxmin", EXE_MULT_OP, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT);
    run_op("multu_maxmax", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
`ifdef MDU_FAST_MUL_EN
    run_op("multu_6x7", EXE_MULTU_OP, 32'd6, 32'd7, 32'd0, 32'd42, 1);
`endif
    run_op("div_neg7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    run_op("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
    run_op("div_7_neg2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT);
    run_op("div_min_m1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT);
    run_op("div_neg5_0", EXE_DIV_OP, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
    run_op("divu_5_0", EXE_DIVU_OP, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);

    // Flush a divide part-way through: HI/LO keep the divu_5_0 result, no done.
    start_i = 1'b1; op_i = EXE_DIV_OP; a_i = 32'd1000; b_i = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    check("flush_pre_stall", 64'(stall_o), 64'd1);
    flush_i = 1'b1;
    #1;
    check("flush_stall_low", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0; op_i = 8'h00;
    #1;
    check("flush_idle_stall", 64'(stall_o), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("flush_no_done", 64'(done_o), 64'd0);
    end
    check("flush_hi_kept", 64'(hi_o), 64'd5);
    check("flush_lo_kept", 64'(lo_o), 64'hFFFF_FFFF);

    start_i = 1'b1; op_i = EXE_MTLO_OP; a_i = 32'h0000_1234;
    #1;
    check("mtlo_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 8'h00;
    check("mtlo_lo", 64'(lo_o), 64'h1234);
    check("mtlo_hi", 64'(hi_o), 64'd5);

    start_i = 1'b1; op_i = EXE_MTHI_OP; a_i = 32'hCAFE_0001; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 8'h00; flush_i = 1'b0;
    check("mthi_flushed", 64'(hi_o), 64'd5);

    start_i = 1'b1; op_i = EXE_MTHI_OP; a_i = 32'hCAFE_0001;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 8'h00;
    check("mthi_hi", 64'(hi_o), 64'hCAFE_0001);
    repeat (2) begin
      @(posedge clk); #1;
      check("mt_no_done", 64'(done_o), 64'd0);
    end

    // Asynchronous reset part-way through a long operation.
    start_i = 1'b1; op_i = RST_OP; a_i = 32'd12345; b_i = 32'd678;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 8'h00;
    repeat (4) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_hi", 64'(hi_o), 64'd0);
    check("arst_lo", 64'(lo_o), 64'd0);
    check("arst_stall", 64'(stall_o), 64'd0);
    check("arst_done", 64'(done_o), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) check("arst_no_done", 64'(done_o), 64'd0);
    end

    run_op("divu_after_rst", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
